crank_axil_arbiter: RTL and testbench
=====================================

CRANK_AXIL_ARBITER -- requirements
Module: crank_axil_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 4, meaning AXI4-Lite address width (bits).
REQ-002 SHALL have parameter DATA_W, fixed 32, meaning AXI4-Lite data width; other values are unsupported.
REQ-003 SHALL have port ACLK  in  1  single clock; all logic rising-edge.
REQ-004 SHALL have port ARESET  in  1  reset, synchronous, active-high.
REQ-005 SHALL have ports reqN_valid  in  1  requester N (N=0,1) command valid.
REQ-006 SHALL have ports reqN_we  in  1  1=write, 0=read; reqN_addr  in  ADDR_W; reqN_wdata  in  32; reqN_wstrb  in  4.
REQ-007 SHALL have ports reqN_ready  out  1  command accepted (one-cycle pulse).
REQ-008 SHALL have ports reqN_done  out  1  completion pulse; reqN_rdata  out  32; reqN_resp  out  2.
REQ-009 SHALL have AXI4-Lite master ports m_axi_awaddr/awprot/awvalid/awready, wdata/wstrb/wvalid/wready, bresp/bvalid/bready, araddr/arprot/arvalid/arready, rdata/rresp/rvalid/rready, standard directions and widths.
REQ-010 SHALL have port busy  out  1  FSM not in IDLE.

Function
REQ-011 SHALL implement FSM states IDLE, WR (AW+W outstanding), WR_RESP, RD_ADDR, RD_DATA.
REQ-012 In IDLE, with any reqN_valid high, SHALL grant exactly one requester, pulse its reqN_ready that cycle, and capture we/addr/wdata/wstrb.
REQ-013 Arbitration SHALL be round-robin: when both requesters are valid, grant the requester not granted last; a single valid requester is granted regardless of history.
REQ-014 Grant SHALL be evaluated only in IDLE; requests arriving while busy wait, keeping reqN_valid high and payload stable until reqN_ready.
REQ-015 Write grant -> WR next cycle with awvalid=1 and wvalid=1 together; each valid drops independently on its own handshake; WR_RESP entered once both handshakes are done, including when both occur in the same cycle.
REQ-016 bready SHALL be 1 only in WR_RESP; on bvalid&bready SHALL latch bresp and go to IDLE.
REQ-017 Read grant -> RD_ADDR next cycle with arvalid=1 until arready; then RD_DATA with rready=1; on rvalid&rready SHALL latch rdata/rresp and go to IDLE.
REQ-018 Each valid SHALL stay asserted until its handshake, and each address/data SHALL stay stable while its valid is high, independent of requester inputs.
REQ-019 reqN_done SHALL pulse for exactly one cycle, the cycle after the B or R handshake, only for the granted N; reqN_rdata/reqN_resp SHALL be valid in that cycle and hold until the next completion to N.
REQ-020 For writes, reqN_rdata SHALL be 0 and reqN_resp = bresp.
REQ-021 A new grant SHALL be allowed in the same cycle as reqN_done (back-to-back); minimum spacing between successive grants SHALL be 3 cycles (grant, address, response).
REQ-022 awprot and arprot SHALL be constant 3'b000.
REQ-023 Error responses (SLVERR, DECERR) SHALL be passed through unchanged and SHALL NOT cause a retry.

Reset
REQ-024 While ARESET=1: state=IDLE; awvalid, wvalid, bready, arvalid, rready, reqN_ready, reqN_done, busy = 0; reqN_rdata = 0; reqN_resp = 0; last-grant = 1, so requester 0 wins the first tie.
REQ-025 ARESET asserted mid-transaction SHALL abort to IDLE on the next edge with no done pulse; the bench SHALL reset the AXI slave concurrently.

Verification
REQ-026 Scenario: req0 writes 0x1,0x2,0x3,0x4 to 0x0,0x4,0x8,0xC, then reads them back -> rdata = 1,2,3,4; resp = 0 each; one req0_done per command.
REQ-027 Scenario: req0 and req1 both valid from reset, 4 commands each -> grants alternate 0,1,0,1,...; no starvation.
REQ-028 Scenario: slave holds awready low 5 cycles with wready immediate, then the reverse; also both same-cycle -> wvalid/awvalid drop independently; exactly one B per write.
REQ-029 Scenario: slave returns rresp=2'b10 for addr 0x8 -> req_resp=2, rdata = slave data, FSM returns to IDLE.
REQ-030 Scenario: ARESET pulsed while in RD_DATA -> all outputs at reset values next cycle; a subsequent read of 0x4 completes correctly.
REQ-031 Scenario: back-to-back req1 reads with zero-wait slave -> grant spacing exactly 3 cycles; done pulse coincides with the next ready.

Source files
------------

// File: rtl/crank_axil_arbiter.sv
// crank_axil_arbiter: round-robin arbiter that serialises commands from two
// requesters onto one AXI4-Lite master port, one transaction at a time.
module crank_axil_arbiter #(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DATA_W = 32
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  // requester 0
  input  logic                  req0_valid,
  input  logic                  req0_we,
  input  logic [ADDR_W-1:0]     req0_addr,
  input  logic [DATA_W-1:0]     req0_wdata,
  input  logic [DATA_W/8-1:0]   req0_wstrb,
  output logic                  req0_ready,
  output logic                  req0_done,
  output logic [DATA_W-1:0]     req0_rdata,
  output logic [1:0]            req0_resp,
  // requester 1
  input  logic                  req1_valid,
  input  logic                  req1_we,
  input  logic [ADDR_W-1:0]     req1_addr,
  input  logic [DATA_W-1:0]     req1_wdata,
  input  logic [DATA_W/8-1:0]   req1_wstrb,
  output logic                  req1_ready,
  output logic                  req1_done,
  output logic [DATA_W-1:0]     req1_rdata,
  output logic [1:0]            req1_resp,
  // AXI4-Lite master
  output logic [ADDR_W-1:0]     m_axi_awaddr,
  output logic [2:0]            m_axi_awprot,
  output logic                  m_axi_awvalid,
  input  logic                  m_axi_awready,
  output logic [DATA_W-1:0]     m_axi_wdata,
  output logic [DATA_W/8-1:0]   m_axi_wstrb,
  output logic                  m_axi_wvalid,
  input  logic                  m_axi_wready,
  input  logic [1:0]            m_axi_bresp,
  input  logic                  m_axi_bvalid,
  output logic                  m_axi_bready,
  output logic [ADDR_W-1:0]     m_axi_araddr,
  output logic [2:0]            m_axi_arprot,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  input  logic [DATA_W-1:0]     m_axi_rdata,
  input  logic [1:0]            m_axi_rresp,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready,
  output logic                  busy
);

  localparam int unsigned STRB_W = DATA_W / 8;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_WR      = 3'd1;
  localparam logic [2:0] ST_WR_RESP = 3'd2;
  localparam logic [2:0] ST_RD_ADDR = 3'd3;
  localparam logic [2:0] ST_RD_DATA = 3'd4;

  logic [2:0]        state_q, state_d;
  logic              gnt_q, gnt_d;       // owner of the transaction in flight
  logic              last_q, last_d;     // requester granted most recently
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [STRB_W-1:0] wstrb_q, wstrb_d;
  logic              awvalid_q, awvalid_d;
  logic              wvalid_q, wvalid_d;
  logic              done0_q, done0_d, done1_q, done1_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic [1:0]        resp0_q, resp0_d, resp1_q, resp1_d;

  logic              pick1_c;
  logic              cpl_c;
  logic [DATA_W-1:0] cpl_rdata_c;
  logic [1:0]        cpl_resp_c;

  // Next-state, grant and completion logic
  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    last_d      = last_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    done0_d     = 1'b0;
    done1_d     = 1'b0;
    rdata0_d    = rdata0_q;
    rdata1_d    = rdata1_q;
    resp0_d     = resp0_q;
    resp1_d     = resp1_q;
    req0_ready  = 1'b0;
    req1_ready  = 1'b0;
    pick1_c     = 1'b0;
    cpl_c       = 1'b0;
    cpl_rdata_c = '0;
    cpl_resp_c  = 2'b00;

    case (state_q)
      ST_IDLE: begin
        if (!ARESET && (req0_valid || req1_valid)) begin
          // On a tie, the requester that was not granted last wins
          pick1_c    = req1_valid && (!req0_valid || !last_q);
          req0_ready = !pick1_c;
          req1_ready = pick1_c;
          gnt_d      = pick1_c;
          last_d     = pick1_c;
          addr_d     = pick1_c ? req1_addr  : req0_addr;
          wdata_d    = pick1_c ? req1_wdata : req0_wdata;
          wstrb_d    = pick1_c ? req1_wstrb : req0_wstrb;
          if (pick1_c ? req1_we : req0_we) begin
            state_d   = ST_WR;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
          end else begin
            state_d   = ST_RD_ADDR;
          end
        end
      end
      ST_WR: begin
        awvalid_d = awvalid_q && !m_axi_awready;
        wvalid_d  = wvalid_q && !m_axi_wready;
        if (!awvalid_d && !wvalid_d) begin
          state_d = ST_WR_RESP;
        end
      end
      ST_WR_RESP: begin
        if (m_axi_bvalid) begin
          state_d    = ST_IDLE;
          cpl_c      = 1'b1;
          cpl_resp_c = m_axi_bresp;
        end
      end
      ST_RD_ADDR: begin
        if (m_axi_arready) begin
          state_d = ST_RD_DATA;
        end
      end
      ST_RD_DATA: begin
        if (m_axi_rvalid) begin
          state_d     = ST_IDLE;
          cpl_c       = 1'b1;
          cpl_rdata_c = m_axi_rdata;
          cpl_resp_c  = m_axi_rresp;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        awvalid_d = 1'b0;
        wvalid_d  = 1'b0;
      end
    endcase

    if (cpl_c) begin
      if (gnt_q) begin
        done1_d  = 1'b1;
        rdata1_d = cpl_rdata_c;
        resp1_d  = cpl_resp_c;
      end else begin
        done0_d  = 1'b1;
        rdata0_d = cpl_rdata_c;
        resp0_d  = cpl_resp_c;
      end
    end
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q   <= ST_IDLE;
      gnt_q     <= 1'b0;
      last_q    <= 1'b1;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      done0_q   <= 1'b0;
      done1_q   <= 1'b0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
      resp0_q   <= 2'b00;
      resp1_q   <= 2'b00;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      last_q    <= last_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      done0_q   <= done0_d;
      done1_q   <= done1_d;
      rdata0_q  <= rdata0_d;
      rdata1_q  <= rdata1_d;
      resp0_q   <= resp0_d;
      resp1_q   <= resp1_d;
    end
  end

  assign m_axi_awaddr  = addr_q;
  assign m_axi_awprot  = 3'b000;
  assign m_axi_awvalid = awvalid_q;
  assign m_axi_wdata   = wdata_q;
  assign m_axi_wstrb   = wstrb_q;
  assign m_axi_wvalid  = wvalid_q;
  assign m_axi_bready  = (state_q == ST_WR_RESP);
  assign m_axi_araddr  = addr_q;
  assign m_axi_arprot  = 3'b000;
  assign m_axi_arvalid = (state_q == ST_RD_ADDR);
  assign m_axi_rready  = (state_q == ST_RD_DATA);
  assign busy          = (state_q != ST_IDLE);

  assign req0_done  = done0_q;
  assign req0_rdata = rdata0_q;
  assign req0_resp  = resp0_q;
  assign req1_done  = done1_q;
  assign req1_rdata = rdata1_q;
  assign req1_resp  = resp1_q;

endmodule

// File: tb/tb_crank_axil_arbiter.sv
// tb_crank_axil_arbiter: directed scenarios with an AXI4-Lite slave model and
// a scoreboard of expected grants and completions.
module tb_crank_axil_arbiter;

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic        req0_valid, req0_we, req0_ready, req0_done;
  logic [3:0]  req0_addr, req0_wstrb;
  logic [31:0] req0_wdata, req0_rdata;
  logic [1:0]  req0_resp;
  logic        req1_valid, req1_we, req1_ready, req1_done;
  logic [3:0]  req1_addr, req1_wstrb;
  logic [31:0] req1_wdata, req1_rdata;
  logic [1:0]  req1_resp;
  logic [3:0]  awaddr, araddr, wstrb;
  logic [2:0]  awprot, arprot;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready, busy;
  logic [31:0] wdata, rdata;
  logic [1:0]  bresp, rresp;

  always #5 ACLK = ~ACLK;

  crank_axil_arbiter #(.ADDR_W(4), .DATA_W(32)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .req0_valid(req0_valid), .req0_we(req0_we), .req0_addr(req0_addr),
    .req0_wdata(req0_wdata), .req0_wstrb(req0_wstrb), .req0_ready(req0_ready),
    .req0_done(req0_done), .req0_rdata(req0_rdata), .req0_resp(req0_resp),
    .req1_valid(req1_valid), .req1_we(req1_we), .req1_addr(req1_addr),
    .req1_wdata(req1_wdata), .req1_wstrb(req1_wstrb), .req1_ready(req1_ready),
    .req1_done(req1_done), .req1_rdata(req1_rdata), .req1_resp(req1_resp),
    .m_axi_awaddr(awaddr), .m_axi_awprot(awprot), .m_axi_awvalid(awvalid),
    .m_axi_awready(awready), .m_axi_wdata(wdata), .m_axi_wstrb(wstrb),
    .m_axi_wvalid(wvalid), .m_axi_wready(wready), .m_axi_bresp(bresp),
    .m_axi_bvalid(bvalid), .m_axi_bready(bready), .m_axi_araddr(araddr),
    .m_axi_arprot(arprot), .m_axi_arvalid(arvalid), .m_axi_arready(arready),
    .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rvalid(rvalid),
    .m_axi_rready(rready), .busy(busy)
  );

  // ---------------- AXI4-Lite slave model ----------------
  int          aw_delay = 0, w_delay = 0, r_delay = 0;
  bit          err_mode = 1'b0;
  int          aw_cnt, w_cnt, r_cnt;
  logic        r_pend, aw_got, w_got;
  logic [3:0]  aw_a, w_s;
  logic [31:0] w_d;
  logic [31:0] mem [4];
  int          aw_hs = 0, w_hs = 0, b_hs = 0;

  assign awready = awvalid && (aw_cnt >= aw_delay);
  assign wready  = wvalid && (w_cnt >= w_delay);
  assign arready = arvalid;
  assign bresp   = 2'b00;

  wire         aw_fire = awvalid && awready;
  wire         w_fire  = wvalid && wready;
  wire         wr_fire = (aw_got || aw_fire) && (w_got || w_fire);
  wire [3:0]   wr_addr = aw_fire ? awaddr : aw_a;
  wire [31:0]  wr_data = w_fire ? wdata : w_d;
  wire [3:0]   wr_strb = w_fire ? wstrb : w_s;

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = n[8*b +: 8];
    return r;
  endfunction

  always @(posedge ACLK) begin
    if (ARESET) begin
      aw_cnt <= 0; w_cnt <= 0; r_cnt <= 0; r_pend <= 1'b0;
      aw_got <= 1'b0; w_got <= 1'b0; bvalid <= 1'b0; rvalid <= 1'b0;
      aw_a <= '0; w_d <= '0; w_s <= '0; rdata <= '0; rresp <= 2'b00;
    end else begin
      aw_cnt <= (awvalid && !awready) ? aw_cnt + 1 : 0;
      w_cnt  <= (wvalid && !wready) ? w_cnt + 1 : 0;
      if (aw_fire) aw_a <= awaddr;
      if (w_fire) begin w_d <= wdata; w_s <= wstrb; end
      aw_got <= wr_fire ? 1'b0 : (aw_got || aw_fire);
      w_got  <= wr_fire ? 1'b0 : (w_got || w_fire);
      if (bvalid && bready) bvalid <= 1'b0;
      if (wr_fire) begin
        mem[wr_addr[3:2]] <= merge(mem[wr_addr[3:2]], wr_data, wr_strb);
        bvalid <= 1'b1;
      end
      if (rvalid && rready) rvalid <= 1'b0;
      if (arvalid && arready) begin
        rdata <= mem[araddr[3:2]];
        rresp <= (err_mode && araddr == 4'h8) ? 2'b10 : 2'b00;
        if (r_delay == 0) rvalid <= 1'b1;
        else begin r_pend <= 1'b1; r_cnt <= r_delay; end
      end else if (r_pend) begin
        if (r_cnt <= 1) begin rvalid <= 1'b1; r_pend <= 1'b0; end
        else r_cnt <= r_cnt - 1;
      end
    end
  end

  always @(posedge ACLK) begin
    if (aw_fire) aw_hs <= aw_hs + 1;
    if (w_fire) w_hs <= w_hs + 1;
    if (bvalid && bready) b_hs <= b_hs + 1;
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    int          port;
    logic [31:0] rdata;
    logic [1:0]  resp;
  } exp_t;

  exp_t exp_q[$];
  int   gnt_q[$];
  int   checks = 0, errors = 0;
  int   cyc = 0;
  int   aw_only = 0, w_only = 0;
  bit   spacing_en = 1'b0, have_prev = 1'b0;
  int   prev_gnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  task automatic expect_cmd(input int port, input logic [31:0] rd, input logic [1:0] rs);
    exp_t e;
    e.port = port; e.rdata = rd; e.resp = rs;
    gnt_q.push_back(port);
    exp_q.push_back(e);
  endtask

  initial forever @(posedge ACLK) cyc++;

  // Monitor: grants, completions and channel independence, sampled on negedge
  initial begin
    exp_t e;
    int   g;
    forever begin
      @(negedge ACLK);
      if (awvalid && !wvalid) aw_only++;
      if (wvalid && !awvalid) w_only++;
      if (!ARESET && (req0_ready || req1_ready)) begin
        chk("one_grant", 32'(req0_ready & req1_ready), 32'd0);
        if (gnt_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_grant actual=port%0d required=none", req1_ready);
        end else begin
          g = gnt_q.pop_front();
          chk("grant_port", 32'(req1_ready), 32'(g));
        end
        if (spacing_en && req1_ready) begin
          if (have_prev) begin
            chk("grant_spacing", 32'(cyc - prev_gnt), 32'd3);
            chk("done_with_ready", 32'(req1_done), 32'd1);
          end
          have_prev = 1'b1;
          prev_gnt  = cyc;
        end
      end
      if (req0_done || req1_done) begin
        chk("busy_at_done", 32'(busy), 32'd0);
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_done actual=done0=%0d,done1=%0d required=none",
                   req0_done, req1_done);
        end else begin
          e = exp_q.pop_front();
          chk("done_port", 32'(req1_done), 32'(e.port));
          chk("done_rdata", req1_done ? req1_rdata : req0_rdata, e.rdata);
          chk("done_resp", 32'(req1_done ? req1_resp : req0_resp), 32'(e.resp));
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input int port, input logic we, input logic [3:0] addr,
                       input logic [31:0] wd);
    bit got;
    got = 1'b0;
    if (port == 0) begin
      req0_valid = 1'b1; req0_we = we; req0_addr = addr; req0_wdata = wd; req0_wstrb = 4'hF;
    end else begin
      req1_valid = 1'b1; req1_we = we; req1_addr = addr; req1_wdata = wd; req1_wstrb = 4'hF;
    end
    for (int k = 0; k < 300 && !got; k++) begin
      @(negedge ACLK);
      got = (port == 0) ? req0_ready : req1_ready;
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL drive_timeout port=%0d actual=no_ready required=ready", port);
    end
    @(posedge ACLK); #1;
    if (port == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 400 && !ok; k++) begin
      @(negedge ACLK);
      ok = (exp_q.size() == 0) && !busy;
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL idle_timeout actual=pending%0d required=0", exp_q.size());
    end
    @(posedge ACLK); #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_busy"},    32'(busy), 32'd0);
    chk({tag, "_ready"},   32'({req0_ready, req1_ready}), 32'd0);
    chk({tag, "_done"},    32'({req0_done, req1_done}), 32'd0);
    chk({tag, "_awvalid"}, 32'(awvalid), 32'd0);
    chk({tag, "_wvalid"},  32'(wvalid), 32'd0);
    chk({tag, "_bready"},  32'(bready), 32'd0);
    chk({tag, "_arvalid"}, 32'(arvalid), 32'd0);
    chk({tag, "_rready"},  32'(rready), 32'd0);
    chk({tag, "_rdata0"},  req0_rdata, 32'd0);
    chk({tag, "_rdata1"},  req1_rdata, 32'd0);
    chk({tag, "_resp"},    32'({req0_resp, req1_resp}), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    bit reached;
    ARESET = 1'b1;
    req0_valid = 1'b0; req0_we = 1'b0; req0_addr = '0; req0_wdata = '0; req0_wstrb = '0;
    req1_valid = 1'b0; req1_we = 1'b0; req1_addr = '0; req1_wdata = '0; req1_wstrb = '0;
    repeat (3) @(posedge ACLK);
    @(negedge ACLK);
    check_reset_outputs("reset");
    chk("prot", 32'({awprot, arprot}), 32'd0);
    ARESET = 1'b0;
    @(posedge ACLK); #1;

    // Write 1..4 to 0x0..0xC, then read back
    for (int i = 0; i < 4; i++) begin
      expect_cmd(0, 32'd0, 2'b00);
      drive(0, 1'b1, 4'(4 * i), 32'(i + 1));
    end
    for (int i = 0; i < 4; i++) begin
      expect_cmd(0, 32'(i + 1), 2'b00);
      drive(0, 1'b0, 4'(4 * i), 32'd0);
    end
    wait_idle();

    // Both requesters contending from reset: grants alternate 0,1,0,1...
    @(negedge ACLK); ARESET = 1'b1;
    @(posedge ACLK); @(negedge ACLK); ARESET = 1'b0;
    @(posedge ACLK); #1;
    for (int i = 0; i < 4; i++) begin
      expect_cmd(0, 32'(i + 1), 2'b00);
      expect_cmd(1, 32'(4 - i), 2'b00);
    end
    fork
      for (int i = 0; i < 4; i++) drive(0, 1'b0, 4'(4 * i), 32'd0);
      for (int j = 0; j < 4; j++) drive(1, 1'b0, 4'(12 - 4 * j), 32'd0);
    join
    wait_idle();

    // Write channel skew: awready late, then wready late, then both at once
    aw_delay = 5; w_delay = 0;
    expect_cmd(0, 32'd0, 2'b00);
    drive(0, 1'b1, 4'h0, 32'h0000_00A1);
    wait_idle();
    aw_delay = 0; w_delay = 5;
    expect_cmd(0, 32'd0, 2'b00);
    drive(0, 1'b1, 4'h4, 32'h0000_00B2);
    wait_idle();
    w_delay = 0;
    expect_cmd(1, 32'd0, 2'b00);
    drive(1, 1'b1, 4'h8, 32'h0000_00C3);
    wait_idle();

    // SLVERR read passes through with the slave data
    err_mode = 1'b1;
    expect_cmd(0, 32'h0000_00C3, 2'b10);
    drive(0, 1'b0, 4'h8, 32'd0);
    wait_idle();
    err_mode = 1'b0;

    // Reset while waiting for R: abort with no completion, then a clean read
    r_delay = 20;
    gnt_q.push_back(0);
    drive(0, 1'b0, 4'h8, 32'd0);
    reached = 1'b0;
    for (int k = 0; k < 50 && !reached; k++) begin
      @(negedge ACLK);
      reached = rready;
    end
    chk("reached_rd_data", 32'(reached), 32'd1);
    ARESET = 1'b1;
    @(posedge ACLK);
    @(negedge ACLK);
    check_reset_outputs("abort");
    ARESET = 1'b0;
    r_delay = 0;
    @(posedge ACLK); #1;
    expect_cmd(0, 32'h0000_00B2, 2'b00);
    drive(0, 1'b0, 4'h4, 32'd0);
    wait_idle();

    // Back-to-back req1 reads against a zero-wait slave
    spacing_en = 1'b1; have_prev = 1'b0;
    expect_cmd(1, 32'h0000_00A1, 2'b00);
    expect_cmd(1, 32'h0000_00B2, 2'b00);
    expect_cmd(1, 32'h0000_00C3, 2'b00);
    expect_cmd(1, 32'h0000_0004, 2'b00);
    for (int i = 0; i < 4; i++) drive(1, 1'b0, 4'(4 * i), 32'd0);
    wait_idle();
    spacing_en = 1'b0;

    repeat (3) @(posedge ACLK);
    @(negedge ACLK);
    chk("aw_handshakes", 32'(aw_hs), 32'd7);
    chk("w_handshakes",  32'(w_hs),  32'd7);
    chk("b_handshakes",  32'(b_hs),  32'd7);
    chk("aw_only_cycles", 32'(aw_only), 32'd5);
    chk("w_only_cycles",  32'(w_only),  32'd5);
    chk("grants_left", 32'(gnt_q.size()), 32'd0);
    chk("dones_left",  32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
